el2_trace_capture: RTL

- Consumer end of the core's per-retirement trace packet (el2_pkg::el2_trace_pkt_t fields).
- Captures each valid retirement into a small packet FIFO and serialises it as 3- or 4-beat 32-bit records on a valid/ready stream.
- The stream feeds the SoC trace funnel or debug buffer.
- Tracks dropped retirements when the FIFO overflows.

---
 rtl/el2_trace_capture.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/el2_trace_capture.sv
// Retirement trace capture: buffers valid retirements in a small packet FIFO
// and serialises each as a 3- or 4-beat 32-bit record on a valid/ready stream.
module el2_trace_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_en,
    input  logic             trace_rv_i_valid_ip,
    input  logic [31:0]      trace_rv_i_insn_ip,
    input  logic [31:0]      trace_rv_i_address_ip,
    input  logic             trace_rv_i_exception_ip,
    input  logic [4:0]       trace_rv_i_ecause_ip,
    input  logic             trace_rv_i_interrupt_ip,
    input  logic [31:0]      trace_rv_i_tval_ip,
    output logic             tx_valid,
    output logic [31:0]      tx_data,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             clr_overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        INSN = 2'd1,
        ADDR = 2'd2,
        TVAL = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] seq;
        logic        loss;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] insn;
        logic [31:0] addr;
        logic [31:0] tval;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    state_t           state_q, state_d;
    logic [15:0]      seq_q, seq_d;
    logic             loss_q, loss_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic   empty_s, full_s, xfer_s, last_s, pop_s, capture_s, push_s, drop_s;
    entry_t head_s, new_s;

    // Header beat: start marker, status flags, cause and sequence number.
    function automatic logic [31:0] hdr_beat(input entry_t e);
        return {1'b1, e.loss, e.exc, e.intr, e.ecause, 7'd0, e.seq};
    endfunction

    // FIFO status and per-cycle handshake decisions.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_s    = mem_q[rd_ptr_q[AW-1:0]];
        xfer_s    = !empty_s && tx_ready;
        case (state_q)
            ADDR:    last_s = !(head_s.exc || head_s.intr);
            TVAL:    last_s = 1'b1;
            default: last_s = 1'b0;
        endcase
        pop_s     = xfer_s && last_s;
        capture_s = trace_en && trace_rv_i_valid_ip;
        push_s    = capture_s && (!full_s || pop_s);
        drop_s    = capture_s && full_s && !pop_s;
    end

    // Stream outputs come only from stored state, never straight from trace inputs.
    always_comb begin
        tx_valid = !empty_s;
        tx_data  = 32'd0;
        tx_last  = 1'b0;
        if (empty_s) begin
            tx_data = 32'd0;
            tx_last = 1'b0;
        end else begin
            tx_last = last_s;
            case (state_q)
                HDR:     tx_data = hdr_beat(head_s);
                INSN:    tx_data = head_s.insn;
                ADDR:    tx_data = head_s.addr;
                TVAL:    tx_data = head_s.tval;
                default: tx_data = 32'd0;
            endcase
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Next-state: FIFO write/pointers, beat FSM, sequence, loss and drop accounting.
    always_comb begin
        mem_d         = mem_q;
        new_s.seq     = seq_q;
        new_s.loss    = loss_q;
        new_s.exc     = trace_rv_i_exception_ip;
        new_s.intr    = trace_rv_i_interrupt_ip;
        new_s.ecause  = trace_rv_i_ecause_ip;
        new_s.insn    = trace_rv_i_insn_ip;
        new_s.addr    = trace_rv_i_address_ip;
        new_s.tval    = trace_rv_i_tval_ip;
        if (push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = new_s;
        end else begin
            mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
        end
        wr_ptr_d = push_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;

        state_d = state_q;
        if (xfer_s) begin
            case (state_q)
                HDR:     state_d = INSN;
                INSN:    state_d = ADDR;
                ADDR:    state_d = last_s ? HDR : TVAL;
                TVAL:    state_d = HDR;
                default: state_d = HDR;
            endcase
        end else begin
            state_d = state_q;
        end

        seq_d = capture_s ? (seq_q + 16'd1) : seq_q;

        // A drop in the same cycle as a clear still counts, so the clear only resets the base.
        drop_cnt_d = clr_overflow ? {CNT_W{1'b0}} : drop_cnt_q;
        if (drop_s && (drop_cnt_d != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_d;
        end
        overflow_d = drop_s ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
        loss_d     = drop_s ? 1'b1 : (push_s ? 1'b0 : loss_q);
    end

    // State registers with asynchronous reset; reset abandons any record in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {$bits(entry_t){1'b0}};
            end
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            state_q    <= HDR;
            seq_q      <= 16'd0;
            loss_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= {CNT_W{1'b0}};
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            seq_q      <= seq_d;
            loss_q     <= loss_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule
